// File: rtl/axis_flit_ejector.sv
// axis_flit_ejector: router output-port ejection endpoint on clk_noc.
// Buffers credit-flow-controlled flits, returns one credit per popped flit and
// packs SERIALIZATION_FACTOR flits into one AXI-Stream beat (flit 0 in LSBs).
// Optional macro FLIT_EJECT_OVERFLOW_CHECK_EN enables the sticky err_overflow
// flag; without it err_overflow is tied low.
//
// Handshake: a beat transfers on a rising edge where axis_out_tvalid and
// axis_out_tready are both high; once tvalid is raised the beat fields hold
// steady and tvalid stays high until that transfer happens.
module axis_flit_ejector #(
  parameter int TDATA_WIDTH          = 32,
  parameter int TID_WIDTH            = 2,
  parameter int TDEST_WIDTH          = 2,
  parameter int SERIALIZATION_FACTOR = 1,
  parameter int FLIT_BUFFER_DEPTH    = 4,
  parameter int FLIT_WIDTH           = TDATA_WIDTH / SERIALIZATION_FACTOR,
  parameter int DEST_WIDTH           = TID_WIDTH + TDEST_WIDTH
) (
  input  logic                   clk_noc,
  input  logic                   rst_n,
  input  logic [FLIT_WIDTH-1:0]  data_in,
  input  logic [DEST_WIDTH-1:0]  dest_in,
  input  logic                   is_tail_in,
  input  logic                   send_in,
  output logic                   credit_out,
  output logic                   axis_out_tvalid,
  input  logic                   axis_out_tready,
  output logic [TDATA_WIDTH-1:0] axis_out_tdata,
  output logic                   axis_out_tlast,
  output logic [TID_WIDTH-1:0]   axis_out_tid,
  output logic [TDEST_WIDTH-1:0] axis_out_tdest,
  output logic                   err_overflow
);

  localparam int ENTRY_W = FLIT_WIDTH + DEST_WIDTH + 1;
  localparam int PTR_W   = (FLIT_BUFFER_DEPTH > 1) ? $clog2(FLIT_BUFFER_DEPTH) : 1;
  localparam int IDX_W   = (SERIALIZATION_FACTOR > 1) ? $clog2(SERIALIZATION_FACTOR) : 1;
  localparam logic [PTR_W:0]   DEPTH_C  = (PTR_W+1)'(FLIT_BUFFER_DEPTH);
  localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(SERIALIZATION_FACTOR - 1);

  logic [ENTRY_W-1:0]     mem [FLIT_BUFFER_DEPTH];
  logic [PTR_W-1:0]       wr_ptr;
  logic [PTR_W-1:0]       rd_ptr;
  logic [PTR_W:0]         count;
  logic [IDX_W-1:0]       idx;
  logic [TDATA_WIDTH-1:0] asm_data;
  logic [TDATA_WIDTH-1:0] beat_next;
  logic [ENTRY_W-1:0]     head;
  logic [FLIT_WIDTH-1:0]  head_data;
  logic [DEST_WIDTH-1:0]  head_dest;
  logic                   head_tail;
  logic                   empty;
  logic                   full;
  logic                   completes;
  logic                   pop;
  logic                   push;

  assign empty     = (count == '0);
  assign full      = (count == DEPTH_C);
  assign head      = mem[rd_ptr];
  assign head_data = head[ENTRY_W-1 -: FLIT_WIDTH];
  assign head_dest = head[DEST_WIDTH:1];
  assign head_tail = head[0];

  // The head flit finishes a beat if it fills the last slot or ends the packet;
  // such a flit may only leave the FIFO when the holding register can take it.
  assign completes = (idx == LAST_IDX) || head_tail;
  assign pop  = !empty && (!completes || !axis_out_tvalid || axis_out_tready);
  assign push = send_in && (!full || pop);

  // Merge the head flit into its slot of the beat being assembled.
  always_comb begin
    beat_next = asm_data;
    for (int k = 0; k < SERIALIZATION_FACTOR; k++) begin
      if (idx == IDX_W'(k)) beat_next[k*FLIT_WIDTH +: FLIT_WIDTH] = head_data;
    end
  end

  // Flit storage: payload array carries no reset, only pointers do.
  always_ff @(posedge clk_noc) begin
    if (push) mem[wr_ptr] <= {data_in, dest_in, is_tail_in};
  end

  // FIFO pointers and occupancy.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + PTR_W'(1);
      if (pop)  rd_ptr <= rd_ptr + PTR_W'(1);
      case ({push, pop})
        2'b10:   count <= count + (PTR_W+1)'(1);
        2'b01:   count <= count - (PTR_W+1)'(1);
        default: count <= count;
      endcase
    end
  end

  // Beat assembly, output holding register and credit return.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n) begin
      idx             <= '0;
      asm_data        <= '0;
      axis_out_tvalid <= 1'b0;
      axis_out_tdata  <= '0;
      axis_out_tlast  <= 1'b0;
      axis_out_tid    <= '0;
      axis_out_tdest  <= '0;
      credit_out      <= 1'b0;
    end else begin
      credit_out <= pop;
      if (axis_out_tvalid && axis_out_tready) axis_out_tvalid <= 1'b0;
      if (pop) begin
        if (completes) begin
          idx             <= '0;
          asm_data        <= '0;
          axis_out_tvalid <= 1'b1;
          axis_out_tdata  <= beat_next;
          axis_out_tlast  <= head_tail;
          axis_out_tid    <= head_dest[DEST_WIDTH-1:TDEST_WIDTH];
          axis_out_tdest  <= head_dest[TDEST_WIDTH-1:0];
        end else begin
          idx      <= idx + IDX_W'(1);
          asm_data <= beat_next;
        end
      end
    end
  end

`ifdef FLIT_EJECT_OVERFLOW_CHECK_EN
  logic overflow_attempt;
  assign overflow_attempt = send_in && full && !pop;

  // Sticky flag for a sender that ignored its credit count.
  always_ff @(posedge clk_noc or negedge rst_n) begin
    if (!rst_n)                err_overflow <= 1'b0;
    else if (overflow_attempt) err_overflow <= 1'b1;
  end
`else
  assign err_overflow = 1'b0;
`endif

endmodule

// File: tb/tb_axis_flit_ejector.sv
// Bench for axis_flit_ejector: instance a (SF=1) and instance b (SF=4, 8-bit flits).
module tb_axis_flit_ejector;

`ifdef FLIT_EJECT_OVERFLOW_CHECK_EN
  localparam logic OVF_EN = 1'b1;
`else
  localparam logic OVF_EN = 1'b0;
`endif

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  // ---------------- instance a: SF=1 ----------------
  logic [31:0] data_a;
  logic [3:0]  dest_a;
  logic        tail_a, send_a, credit_a, tvalid_a, tready_a, tlast_a, err_a;
  logic [31:0] tdata_a;
  logic [1:0]  tid_a, tdest_a;

  axis_flit_ejector #(.SERIALIZATION_FACTOR(1), .FLIT_BUFFER_DEPTH(4)) u_a (
    .clk_noc(clk), .rst_n(rst_n), .data_in(data_a), .dest_in(dest_a),
    .is_tail_in(tail_a), .send_in(send_a), .credit_out(credit_a),
    .axis_out_tvalid(tvalid_a), .axis_out_tready(tready_a),
    .axis_out_tdata(tdata_a), .axis_out_tlast(tlast_a), .axis_out_tid(tid_a),
    .axis_out_tdest(tdest_a), .err_overflow(err_a));

  // ---------------- instance b: SF=4 ----------------
  logic [7:0]  data_b;
  logic [3:0]  dest_b;
  logic        tail_b, send_b, credit_b, tvalid_b, tready_b, tlast_b, err_b;
  logic [31:0] tdata_b;
  logic [1:0]  tid_b, tdest_b;

  axis_flit_ejector #(.SERIALIZATION_FACTOR(4), .FLIT_BUFFER_DEPTH(4)) u_b (
    .clk_noc(clk), .rst_n(rst_n), .data_in(data_b), .dest_in(dest_b),
    .is_tail_in(tail_b), .send_in(send_b), .credit_out(credit_b),
    .axis_out_tvalid(tvalid_b), .axis_out_tready(tready_b),
    .axis_out_tdata(tdata_b), .axis_out_tlast(tlast_b), .axis_out_tid(tid_b),
    .axis_out_tdest(tdest_b), .err_overflow(err_b));

  // ---------------- scoreboard state ----------------
  logic [36:0] exp_q_a[$];
  logic [36:0] exp_q_b[$];
  logic [36:0] obs_a[$];
  logic [36:0] obs_b[$];
  int cred_a = 0;
  int cred_b = 0;
  int n_cmp = 0;
  int n_err = 0;
  int c0;

  // Capture accepted beats and credit pulses between clock edges.
  always @(negedge clk) begin
    if (rst_n) begin
      if (tvalid_a && tready_a) obs_a.push_back({tlast_a, tid_a, tdest_a, tdata_a});
      if (tvalid_b && tready_b) obs_b.push_back({tlast_b, tid_b, tdest_b, tdata_b});
      if (credit_a) cred_a++;
      if (credit_b) cred_b++;
    end
  end

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_cmp++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h", tag, got, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic drive_a(input logic [31:0] d, input logic [3:0] dst, input logic tl);
    data_a = d; dest_a = dst; tail_a = tl; send_a = 1'b1;
    @(posedge clk); #1;
    send_a = 1'b0;
  endtask

  task automatic drive_b(input logic [7:0] d, input logic [3:0] dst, input logic tl);
    data_b = d; dest_b = dst; tail_b = tl; send_b = 1'b1;
    @(posedge clk); #1;
    send_b = 1'b0;
  endtask

  task automatic wait_cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic expect_a(input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (obs_a.size() == 0 && w < 200) begin @(posedge clk); w++; end
      if (obs_a.size() == 0) begin
        check("beat_a_timeout", 64'(obs_a.size()), 64'd1);
        return;
      end
      check("beat_a", obs_a.pop_front(), exp_q_a.pop_front());
    end
  endtask

  task automatic expect_b(input int n);
    for (int i = 0; i < n; i++) begin
      int w = 0;
      while (obs_b.size() == 0 && w < 200) begin @(posedge clk); w++; end
      if (obs_b.size() == 0) begin
        check("beat_b_timeout", 64'(obs_b.size()), 64'd1);
        return;
      end
      check("beat_b", obs_b.pop_front(), exp_q_b.pop_front());
    end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // ---------------- directed sequence ----------------
  initial begin
    rst_n = 1'b0;
    data_a = '0; dest_a = '0; tail_a = 1'b0; send_a = 1'b0; tready_a = 1'b1;
    data_b = '0; dest_b = '0; tail_b = 1'b0; send_b = 1'b0; tready_b = 1'b1;
    wait_cycles(3);

    // Reset state
    check("rst_tvalid_a", tvalid_a, 1'b0);
    check("rst_tdata_a",  tdata_a, 32'h0);
    check("rst_side_a",   {tlast_a, tid_a, tdest_a}, 5'h0);
    check("rst_credit_a", credit_a, 1'b0);
    check("rst_err_a",    err_a, 1'b0);
    check("rst_tvalid_b", tvalid_b, 1'b0);
    rst_n = 1'b1;
    wait_cycles(2);

    // SF=1 single flit: tvalid and credit two cycles after send
    c0 = cred_a;
    exp_q_a.push_back({1'b1, 2'b10, 2'b11, 32'hDEADBEEF});
    drive_a(32'hDEADBEEF, 4'b1011, 1'b1);
    check("t1_tvalid_early", tvalid_a, 1'b0);
    check("t1_credit_early", credit_a, 1'b0);
    wait_cycles(1);
    check("t1_tvalid", tvalid_a, 1'b1);
    check("t1_credit", credit_a, 1'b1);
    check("t1_tdata",  tdata_a, 32'hDEADBEEF);
    check("t1_tid",    tid_a, 2'b10);
    check("t1_tdest",  tdest_a, 2'b11);
    check("t1_tlast",  tlast_a, 1'b1);
    expect_a(1);
    wait_cycles(1);
    check("t1_tvalid_drop", tvalid_a, 1'b0);
    check("t1_credits", 64'(cred_a - c0), 64'd1);

    // SF=4 full packet: one beat, tvalid at t+5
    c0 = cred_b;
    exp_q_b.push_back({1'b1, 2'b01, 2'b10, 32'h44332211});
    drive_b(8'h11, 4'b0110, 1'b0);
    drive_b(8'h22, 4'b0110, 1'b0);
    drive_b(8'h33, 4'b0110, 1'b0);
    drive_b(8'h44, 4'b0110, 1'b1);
    check("t2_tvalid_early", tvalid_b, 1'b0);
    wait_cycles(1);
    check("t2_tvalid", tvalid_b, 1'b1);
    expect_b(1);
    wait_cycles(3);
    check("t2_credits", 64'(cred_b - c0), 64'd4);

    // SF=4 early tail, then packets assembling from flit 0, incl. a non-last beat
    c0 = cred_b;
    exp_q_b.push_back({1'b1, 2'b10, 2'b01, 32'h0000BBAA});
    exp_q_b.push_back({1'b1, 2'b00, 2'b00, 32'h04030201});
    exp_q_b.push_back({1'b0, 2'b11, 2'b11, 32'h53525150});
    exp_q_b.push_back({1'b1, 2'b11, 2'b11, 32'h57565554});
    drive_b(8'hAA, 4'b1001, 1'b0);
    drive_b(8'hBB, 4'b1001, 1'b1);
    for (int i = 1; i <= 4; i++) drive_b(8'(i), 4'b0000, (i == 4));
    for (int i = 0; i < 8; i++) drive_b(8'h50 + 8'(i), 4'b1111, (i == 7));
    expect_b(4);
    wait_cycles(3);
    check("t3_credits", 64'(cred_b - c0), 64'd14);

    // SF=1 stall: 5 flits fit (4 FIFO + holding), the 6th overflows
    tready_a = 1'b0;
    c0 = cred_a;
    for (int i = 0; i < 5; i++) begin
      drive_a(32'h10000000 + 32'(i), 4'(i), 1'b1);
      exp_q_a.push_back({1'b1, 2'(i >> 2), 2'(i), 32'h10000000 + 32'(i)});
    end
    drive_a(32'h00000BAD, 4'b1111, 1'b1);
    wait_cycles(4);
    check("t4_hold_tvalid", tvalid_a, 1'b1);
    check("t4_hold_tdata",  tdata_a, 32'h10000000);
    check("t4_stall_credits", 64'(cred_a - c0), 64'd1);
    check("t4_err", err_a, OVF_EN);
    wait_cycles(3);
    check("t4_err_sticky", err_a, OVF_EN);
    tready_a = 1'b1;
    expect_a(5);
    wait_cycles(6);
    check("t4_no_extra_beat", 64'(obs_a.size()), 64'd0);
    check("t4_credits", 64'(cred_a - c0), 64'd5);

    // Asynchronous reset mid-packet with a held beat in a and partial beat in b
    tready_a = 1'b0;
    drive_a(32'hCAFE0001, 4'b0101, 1'b1);
    drive_b(8'hE1, 4'b0000, 1'b0);
    drive_b(8'hE2, 4'b0000, 1'b0);
    wait_cycles(2);
    check("t5_pre_tvalid", tvalid_a, 1'b1);
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_rst_tvalid", tvalid_a, 1'b0);
    check("t5_rst_tdata",  tdata_a, 32'h0);
    check("t5_rst_side",   {tlast_a, tid_a, tdest_a}, 5'h0);
    check("t5_rst_err",    err_a, 1'b0);
    check("t5_rst_credit", credit_a, 1'b0);
    wait_cycles(2);
    rst_n = 1'b1;
    tready_a = 1'b1;
    c0 = cred_a;
    wait_cycles(4);
    check("t5_a_empty", tvalid_a, 1'b0);
    check("t5_a_no_credit", 64'(cred_a - c0), 64'd0);
    exp_q_b.push_back({1'b1, 2'b00, 2'b01, 32'h0D0C0B0A});
    for (int i = 0; i < 4; i++) drive_b(8'h0A + 8'(i), 4'b0001, (i == 3));
    expect_b(1);
    wait_cycles(4);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
